// File: rtl/kvs_pkg.sv
// Shared request-path definitions for the KVS network and DB stages.
// Default key/flag widths, the request record, and a width helper for pacing counters.
package kvs_pkg;

    localparam int KVS_KEY_SIZE  = 96;
    localparam int KVS_FLAG_SIZE = 4;

    typedef struct packed {
        logic [KVS_KEY_SIZE-1:0]  key;
        logic [KVS_FLAG_SIZE-1:0] flag;
    } kvs_req_t;

    // Counter width able to hold gap-1 plus a spare bit: ceil(log2(gap)) + 1.
    function automatic int gap_width(input int gap);
        return $clog2(gap) + 1;
    endfunction

endpackage

// File: rtl/kvs_req_fifo_ram.sv
// Simple dual-port request storage: one write port, one registered read port.
// The array itself is never reset; only the read-data register is.
module kvs_req_fifo_ram #(
    parameter int DATA_W = 100,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-first: a same-address write in this cycle is not visible until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/kvs_req_queue.sv
// Request buffer between the Ethernet parser and the DB lookup stage.
// Absorbs bursts in a circular FIFO, re-issues at most one request per ISSUE_GAP cycles, counts overflow drops.
module kvs_req_queue
    import kvs_pkg::*;
#(
    parameter int KEY_SIZE   = KVS_KEY_SIZE,
    parameter int FLAG_SIZE  = KVS_FLAG_SIZE,
    parameter int DEPTH_LOG2 = 4,
    parameter int ISSUE_GAP  = 4,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_SIZE-1:0]   in_key,
    input  logic [FLAG_SIZE-1:0]  in_flag,
    input  logic                  in_valid,
    output logic [KEY_SIZE-1:0]   out_key,
    output logic [FLAG_SIZE-1:0]  out_flag,
    output logic                  out_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int GAP_W  = gap_width(ISSUE_GAP);
    localparam int DATA_W = KEY_SIZE + FLAG_SIZE;

    localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [GAP_W-1:0]      GAP_LOAD   = GAP_W'(ISSUE_GAP - 1);
    localparam logic [GAP_W-1:0]      GAP_ONE    = GAP_W'(1);
    localparam logic [DROP_CNT_W-1:0] DROP_ONE   = DROP_CNT_W'(1);

    typedef struct packed {
        logic [KEY_SIZE-1:0]  key;
        logic [FLAG_SIZE-1:0] flag;
    } req_t;

    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   level_reg;
    logic [DEPTH_LOG2:0]   level_next;
    logic [GAP_W-1:0]      gap_cnt_reg;
    logic [GAP_W-1:0]      gap_cnt_next;
    logic [DROP_CNT_W-1:0] drop_cnt_reg;
    logic [DROP_CNT_W-1:0] drop_cnt_next;
    logic                  out_valid_reg;

    logic push;
    logic pop;
    logic drop;
    req_t wr_req;
    req_t rd_req;

    assign full  = (level_reg == LEVEL_FULL);
    assign empty = (level_reg == '0);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept the incoming request.
    assign pop  = !empty && (gap_cnt_reg == '0);
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LEVEL_ONE;
            2'b01:   level_next = level_reg - LEVEL_ONE;
            default: level_next = level_reg;
        endcase
    end

    always_comb begin
        gap_cnt_next = gap_cnt_reg;
        if (pop) begin
            gap_cnt_next = GAP_LOAD;
        end else if (gap_cnt_reg != '0) begin
            gap_cnt_next = gap_cnt_reg - GAP_ONE;
        end
    end

    // Saturating: once all-ones the count sticks rather than wrapping.
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (drop && (drop_cnt_reg != '1)) begin
            drop_cnt_next = drop_cnt_reg + DROP_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            gap_cnt_reg   <= '0;
            drop_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            level_reg     <= level_next;
            gap_cnt_reg   <= gap_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
            out_valid_reg <= pop;
        end
    end

    assign wr_req.key  = in_key;
    assign wr_req.flag = in_flag;

    // The RAM read register doubles as the output key/flag register and holds between pops.
    kvs_req_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_req),
        .rd_en   (pop),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_req)
    );

    assign out_key   = rd_req.key;
    assign out_flag  = rd_req.flag;
    assign out_valid = out_valid_reg;
    assign level     = level_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_kvs_req_queue.sv
// Self-checking bench for kvs_req_queue: reference model feeds a scoreboard queue,
// per-scenario tasks drive stimulus and compare observed outputs on the falling edge.
module tb_kvs_req_queue;

    localparam int KEY_SIZE   = 96;
    localparam int FLAG_SIZE  = 4;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
    localparam int ISSUE_GAP  = 4;
    localparam int DROP_CNT_W = 16;
    localparam int GAP_W      = $clog2(ISSUE_GAP) + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [KEY_SIZE-1:0]   in_key = '0;
    logic [FLAG_SIZE-1:0]  in_flag = '0;
    logic                  in_valid = 1'b0;
    logic                  sat_valid = 1'b0;

    logic [KEY_SIZE-1:0]   out_key;
    logic [FLAG_SIZE-1:0]  out_flag;
    logic                  out_valid;
    logic [DEPTH_LOG2:0]   level;
    logic                  full;
    logic                  empty;
    logic [DROP_CNT_W-1:0] drop_cnt;

    logic [KEY_SIZE-1:0]   sat_out_key;
    logic [FLAG_SIZE-1:0]  sat_out_flag;
    logic                  sat_out_valid;
    logic [DEPTH_LOG2:0]   sat_level;
    logic                  sat_full;
    logic                  sat_empty;
    logic [3:0]            sat_drop_cnt;

    int checks = 0;
    int errors = 0;
    int since_last = 1000;
    int issued = 0;
    logic [KEY_SIZE-1:0] last_issue_key = '0;

    always #5 clk = ~clk;

    kvs_req_queue #(
        .KEY_SIZE(KEY_SIZE), .FLAG_SIZE(FLAG_SIZE), .DEPTH_LOG2(DEPTH_LOG2),
        .ISSUE_GAP(ISSUE_GAP), .DROP_CNT_W(DROP_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_key(in_key), .in_flag(in_flag), .in_valid(in_valid),
        .out_key(out_key), .out_flag(out_flag), .out_valid(out_valid), .level(level),
        .full(full), .empty(empty), .drop_cnt(drop_cnt)
    );

    kvs_req_queue #(
        .KEY_SIZE(KEY_SIZE), .FLAG_SIZE(FLAG_SIZE), .DEPTH_LOG2(DEPTH_LOG2),
        .ISSUE_GAP(ISSUE_GAP), .DROP_CNT_W(4)
    ) dut_sat (
        .clk(clk), .rst(rst), .in_key(in_key), .in_flag(in_flag), .in_valid(sat_valid),
        .out_key(sat_out_key), .out_flag(sat_out_flag), .out_valid(sat_out_valid), .level(sat_level),
        .full(sat_full), .empty(sat_empty), .drop_cnt(sat_drop_cnt)
    );

    // Reference model of the main instance; accepted requests go to the scoreboard queue.
    logic [DEPTH_LOG2:0]   m_level = '0;
    logic [GAP_W-1:0]      m_gap = '0;
    logic [DROP_CNT_W-1:0] m_drop = '0;
    logic                  m_out_valid = 1'b0;
    logic                  m_full;
    logic                  m_pop;
    logic                  m_push;
    logic [KEY_SIZE+FLAG_SIZE-1:0] exp_q[$];

    assign m_full = (m_level == (DEPTH_LOG2+1)'(DEPTH));
    assign m_pop  = (m_level != '0) && (m_gap == '0);
    assign m_push = in_valid && (!m_full || m_pop);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_level     <= '0;
            m_gap       <= '0;
            m_drop      <= '0;
            m_out_valid <= 1'b0;
            exp_q.delete();
        end else begin
            if (m_push) exp_q.push_back({in_key, in_flag});
            if (m_push && !m_pop) m_level <= m_level + (DEPTH_LOG2+1)'(1);
            else if (m_pop && !m_push) m_level <= m_level - (DEPTH_LOG2+1)'(1);
            if (m_pop) m_gap <= GAP_W'(ISSUE_GAP - 1);
            else if (m_gap != '0) m_gap <= m_gap - GAP_W'(1);
            if (in_valid && !m_push && m_drop != '1) m_drop <= m_drop + DROP_CNT_W'(1);
            m_out_valid <= m_pop;
        end
    end

    // One clock of stimulus, then falling-edge comparison against model and scoreboard.
    task automatic step(input logic v, input logic [KEY_SIZE-1:0] k, input logic [FLAG_SIZE-1:0] f);
        logic [KEY_SIZE+FLAG_SIZE-1:0] e;
        in_valid = v;
        in_key   = k;
        in_flag  = f;
        @(negedge clk);
        since_last++;
        checks++;
        if (out_valid !== m_out_valid) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_out_valid, $time);
        end
        checks++;
        if (level !== m_level) begin
            errors++;
            $display("FAIL level: got %0d expected %0d at %0t", level, m_level, $time);
        end
        checks++;
        if (drop_cnt !== m_drop) begin
            errors++;
            $display("FAIL drop_cnt: got %0d expected %0d at %0t", drop_cnt, m_drop, $time);
        end
        if (out_valid === 1'b1) begin
            issued++;
            last_issue_key = out_key;
            checks++;
            if (since_last < ISSUE_GAP) begin
                errors++;
                $display("FAIL issue_gap: got %0d cycles expected >= %0d at %0t", since_last, ISSUE_GAP, $time);
            end
            since_last = 0;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got key %0h expected no issue at %0t", out_key, $time);
            end else begin
                e = exp_q.pop_front();
                if ({out_key, out_flag} !== e) begin
                    errors++;
                    $display("FAIL issue_data: got %0h/%0h expected %0h/%0h at %0t",
                             out_key, out_flag, e[KEY_SIZE+FLAG_SIZE-1:FLAG_SIZE], e[FLAG_SIZE-1:0], $time);
                end
                $display("issue key=%0h flag=%0h at %0t", out_key, out_flag, $time);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_level != '0) && n < 300) begin
            step(1'b0, '0, '0);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (ISSUE_GAP) step(1'b0, '0, '0);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0 || level !== '0 || empty !== 1'b1 || full !== 1'b0 || drop_cnt !== '0
            || out_key !== '0 || out_flag !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b lvl=%0d e=%b f=%b d=%0d k=%0h fl=%0h expected 0/0/1/0/0/0/0",
                     out_valid, level, empty, full, drop_cnt, out_key, out_flag);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        step(1'b1, 96'h1, 4'h2);
        checks++;
        if (out_valid !== 1'b0 || level !== 5'd1) begin
            errors++;
            $display("FAIL single_push: got v=%b lvl=%0d expected 0/1", out_valid, level);
        end
        step(1'b0, '0, '0);
        checks++;
        if (out_valid !== 1'b1 || out_key !== 96'h1 || out_flag !== 4'h2 || level !== '0 || drop_cnt !== '0) begin
            errors++;
            $display("FAIL single_issue: got v=%b k=%0h f=%0h lvl=%0d d=%0d expected 1/1/2/0/0",
                     out_valid, out_key, out_flag, level, drop_cnt);
        end
        step(1'b0, '0, '0);
        checks++;
        if (out_valid !== 1'b0 || out_key !== 96'h1 || out_flag !== 4'h2) begin
            errors++;
            $display("FAIL single_hold: got v=%b k=%0h f=%0h expected 0/1/2", out_valid, out_key, out_flag);
        end
    endtask

    task automatic test_burst();
        int peak = 0;
        int pulse_t[$];
        logic [KEY_SIZE-1:0] keys[$];
        drain();
        for (int i = 0; i < 35; i++) begin
            if (i < 5) step(1'b1, KEY_SIZE'(i + 1), FLAG_SIZE'(i + 1));
            else step(1'b0, '0, '0);
            if (int'(level) > peak) peak = int'(level);
            if (out_valid === 1'b1) begin
                pulse_t.push_back(i);
                keys.push_back(out_key);
            end
        end
        checks++;
        if (pulse_t.size() != 5) begin
            errors++;
            $display("FAIL burst_count: got %0d expected 5", pulse_t.size());
        end
        for (int j = 0; j < pulse_t.size(); j++) begin
            checks++;
            if (keys[j] !== KEY_SIZE'(j + 1)) begin
                errors++;
                $display("FAIL burst_order: got %0h expected %0h", keys[j], j + 1);
            end
            if (j > 0) begin
                checks++;
                if (pulse_t[j] - pulse_t[j-1] != ISSUE_GAP) begin
                    errors++;
                    $display("FAIL burst_spacing: got %0d expected %0d", pulse_t[j] - pulse_t[j-1], ISSUE_GAP);
                end
            end
        end
        checks++;
        if (peak != 4) begin
            errors++;
            $display("FAIL burst_peak: got %0d expected 4", peak);
        end
    endtask

    task automatic test_overflow();
        int peak = 0;
        bit full_seen = 0;
        int issued0;
        drain();
        issued0 = issued;
        // 24 back-to-back requests: full after 21, one accepted push+pop, then two drops.
        for (int i = 0; i < 24; i++) begin
            step(1'b1, KEY_SIZE'(100 + i), FLAG_SIZE'(i));
            if (int'(level) > peak) peak = int'(level);
            if (full === 1'b1) full_seen = 1;
        end
        checks++;
        if (peak != DEPTH || !full_seen) begin
            errors++;
            $display("FAIL overflow_fill: got peak=%0d full_seen=%0d expected 16/1", peak, full_seen);
        end
        checks++;
        if (drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL overflow_drops: got %0d expected 2", drop_cnt);
        end
        drain();
        checks++;
        if (issued - issued0 != 22) begin
            errors++;
            $display("FAIL overflow_issued: got %0d expected 22", issued - issued0);
        end
    endtask

    task automatic test_full_push_pop();
        bit hit = 0;
        logic [DROP_CNT_W-1:0] exp_drop;
        drain();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, KEY_SIZE'(200 + i), FLAG_SIZE'(i));
            if (m_full && m_pop) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit || full !== 1'b1) begin
            errors++;
            $display("FAIL fpp_setup: got hit=%0d full=%b expected 1/1", hit, full);
        end
        exp_drop = m_drop;
        step(1'b1, 96'hABCD, 4'hA);
        checks++;
        if (level !== 5'd16 || drop_cnt !== exp_drop || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL fpp_accept: got lvl=%0d d=%0d v=%b expected 16/%0d/1", level, drop_cnt, out_valid, exp_drop);
        end
        drain();
        checks++;
        if (last_issue_key !== 96'hABCD) begin
            errors++;
            $display("FAIL fpp_issued: got %0h expected abcd", last_issue_key);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit hit = 0;
        drain();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, KEY_SIZE'(300 + i), FLAG_SIZE'(i));
            if (m_level == 5'd7 && m_out_valid) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: got hit=%0d v=%b expected 1/1", hit, out_valid);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== '0 || empty !== 1'b1 || full !== 1'b0 || drop_cnt !== '0
            || out_key !== '0) begin
            errors++;
            $display("FAIL rst_async: got v=%b lvl=%0d e=%b f=%b d=%0d k=%0h expected 0/0/1/0/0/0",
                     out_valid, level, empty, full, drop_cnt, out_key);
        end
        #1 rst = 1'b0;
        since_last = 1000;
        @(negedge clk);
        step(1'b1, 96'h55, 4'h5);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_push: got v=%b expected 0", out_valid);
        end
        step(1'b0, '0, '0);
        checks++;
        if (out_valid !== 1'b1 || out_key !== 96'h55 || out_flag !== 4'h5) begin
            errors++;
            $display("FAIL rst_first_issue: got v=%b k=%0h f=%0h expected 1/55/5", out_valid, out_key, out_flag);
        end
    endtask

    task automatic test_saturation();
        drain();
        sat_valid = 1'b1;
        // Same fill pattern as the main queue: drops begin on edge 23, pops every 4th edge from 26.
        for (int k = 1; k <= 100; k++) begin
            step(1'b0, '0, '0);
            if (k == 22 || k == 23 || k == 40 || k == 41 || k == 100) begin
                checks++;
                if (sat_drop_cnt !== ((k == 22) ? 4'd0 : (k == 23) ? 4'd1 : (k == 40) ? 4'd14 : 4'd15)) begin
                    errors++;
                    $display("FAIL sat_drop_k%0d: got %0d expected %0d", k, sat_drop_cnt,
                             (k == 22) ? 0 : (k == 23) ? 1 : (k == 40) ? 14 : 15);
                end
            end
        end
        checks++;
        if (sat_full !== 1'b1) begin
            errors++;
            $display("FAIL sat_full: got %b expected 1", sat_full);
        end
        sat_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_burst();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
